gamma_ctrl: RTL and testbench

Gamma-cycle sequencer for the temporal `mem` delay/storage elements. It derives the gamma-cycle phase from `aclk`, emits the one-cycle `grst` boundary pulse that all `mem` instances share, and supports run/stop sequencing. It arbitrates per-instance clear requests so that each clear lands exactly on a gamma boundary, concurrent with `grst`. It also publishes an input-launch window so that upstream spike sources never drive a pulse across a boundary.

---
 rtl/gamma_ctrl.sv | 68 ++++++
 tb/tb_gamma_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/gamma_ctrl.sv
// gamma_ctrl: gamma-cycle sequencer issuing grst boundaries, boundary-aligned clears and an input-launch window
module gamma_ctrl #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 4,
  parameter int NUM_MEM           = 4
) (
  input  logic                                 aclk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic [NUM_MEM-1:0]                   clr_req,
  output logic                                 grst,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] gamma_phase,
  output logic [15:0]                          gamma_count,
  output logic                                 in_window,
  output logic [NUM_MEM-1:0]                   mem_rst,
  output logic [NUM_MEM-1:0]                   clr_ack,
  output logic                                 busy
);
  localparam int phw = $clog2(GAMMA_CYCLE_WIDTH);
  localparam logic [phw-1:0] c_last = phw'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [phw-1:0] c_win_hi = phw'(GAMMA_CYCLE_WIDTH - 1 - PULSE_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t               r_state, w_next;
  logic [phw-1:0]       r_phase, w_phase_nxt;
  logic                 r_grst;
  logic [15:0]          r_count;
  logic [NUM_MEM-1:0]   r_mem_rst, r_pending;
  logic                 w_boundary, w_launch;
  assign w_boundary = (r_state != IDLE) && (r_phase == c_last);
  assign w_launch   = (r_state == IDLE) && start;
  // State register; STOPPING lingers through the final grst cycle (phase 0) so busy covers it
  always_ff @(posedge aclk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // Next-state: start only acts in IDLE, stop only in RUN, STOPPING exits after its last boundary
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (stop ? STOPPING : RUN) :
             ((r_phase == '0) ? IDLE : STOPPING);
    w_phase_nxt = (r_state == IDLE || w_next == IDLE || r_phase == c_last) ? '0 : r_phase + phw'(1);
  end
  // Outputs decoded from registered state and phase
  always_comb begin
    busy      = r_state != IDLE;
    in_window = (r_state == RUN) && (r_phase != '0) && (r_phase <= c_win_hi);
  end
  // Phase, boundary pulse, gamma count and clear arbitration
  always_ff @(posedge aclk or posedge rst)
    if (rst) begin
      r_phase   <= '0;
      r_grst    <= 1'b0;
      r_count   <= '0;
      r_mem_rst <= '0;
      r_pending <= '0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_grst    <= w_launch | w_boundary;
      r_count   <= w_launch ? 16'd0 : (w_boundary && r_count != 16'hFFFF) ? r_count + 16'd1 : r_count;
      r_mem_rst <= w_boundary ? (r_pending | clr_req) : '0;
      r_pending <= w_boundary ? '0 : (r_pending | clr_req);
    end
  assign grst        = r_grst;
  assign gamma_phase = r_phase;
  assign gamma_count = r_count;
  assign mem_rst     = r_mem_rst;
  assign clr_ack     = r_mem_rst;
endmodule

// File: tb/tb_gamma_ctrl.sv
// tb_gamma_ctrl: table-driven directed check of gamma_ctrl with G=16, P=4, four requesters
module tb_gamma_ctrl;
  logic        aclk, rst, start, stop;
  logic [3:0]  clr_req, mem_rst, clr_ack, gamma_phase;
  logic        grst, in_window, busy;
  logic [15:0] gamma_count;
  int          total, bad;
  typedef struct {
    int          n;
    logic        st, sp;
    logic [3:0]  clr;
    int          ng;
    logic        g;
    logic [3:0]  ph;
    logic [15:0] cnt;
    logic [3:0]  m;
    logic        b, w;
  } vec_t;
  vec_t tbl[$];
  gamma_ctrl #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(4), .NUM_MEM(4)) dut (
    .aclk(aclk), .rst(rst), .start(start), .stop(stop), .clr_req(clr_req),
    .grst(grst), .gamma_phase(gamma_phase), .gamma_count(gamma_count),
    .in_window(in_window), .mem_rst(mem_rst), .clr_ack(clr_ack), .busy(busy)
  );
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic add(input int n, input logic st, sp, input logic [3:0] clr, input int ng,
                     input logic g, input logic [3:0] ph, input logic [15:0] cnt,
                     input logic [3:0] m, input logic b, w);
    vec_t v;
    v = '{n: n, st: st, sp: sp, clr: clr, ng: ng, g: g, ph: ph, cnt: cnt, m: m, b: b, w: w};
    tbl.push_back(v);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " grst"}, 32'(grst), 0);
    chk({nm, " phase"}, 32'(gamma_phase), 0);
    chk({nm, " count"}, 32'(gamma_count), 0);
    chk({nm, " win"}, 32'(in_window), 0);
    chk({nm, " mem_rst"}, 32'(mem_rst), 0);
    chk({nm, " clr_ack"}, 32'(clr_ack), 0);
    chk({nm, " busy"}, 32'(busy), 0);
  endtask
  initial begin
    int ng;
    total = 0;
    bad = 0;
    start = 0;
    stop = 0;
    clr_req = '0;
    rst = 0;
    // n  st sp clr  ng g ph  cnt m  b w
    add(1,  1, 0, 4'h0, 1, 1, 0,  0, 4'h0, 1, 0);
    add(5,  0, 0, 4'h0, 0, 0, 5,  0, 4'h0, 1, 1);
    add(1,  0, 0, 4'h4, 0, 0, 6,  0, 4'h0, 1, 1);
    add(5,  0, 0, 4'h0, 0, 0, 11, 0, 4'h0, 1, 1);
    add(1,  0, 0, 4'h0, 0, 0, 12, 0, 4'h0, 1, 0);
    add(3,  0, 0, 4'h0, 0, 0, 15, 0, 4'h0, 1, 0);
    add(1,  0, 0, 4'h1, 1, 1, 0,  1, 4'h5, 1, 0);
    add(1,  0, 0, 4'h2, 0, 0, 1,  1, 4'h0, 1, 1);
    add(14, 0, 0, 4'h0, 0, 0, 15, 1, 4'h0, 1, 0);
    add(1,  0, 0, 4'h0, 1, 1, 0,  2, 4'h2, 1, 0);
    add(1,  1, 0, 4'h0, 0, 0, 1,  2, 4'h0, 1, 1);
    add(14, 0, 0, 4'h8, 0, 0, 15, 2, 4'h0, 1, 0);
    add(1,  0, 0, 4'h8, 1, 1, 0,  3, 4'h8, 1, 0);
    add(15, 0, 0, 4'h8, 0, 0, 15, 3, 4'h0, 1, 0);
    add(1,  0, 0, 4'h8, 1, 1, 0,  4, 4'h8, 1, 0);
    add(1,  0, 0, 4'h0, 0, 0, 1,  4, 4'h0, 1, 1);
    add(6,  0, 0, 4'h0, 0, 0, 7,  4, 4'h0, 1, 1);
    add(1,  0, 1, 4'h0, 0, 0, 8,  4, 4'h0, 1, 0);
    add(1,  0, 0, 4'h0, 0, 0, 9,  4, 4'h0, 1, 0);
    add(1,  0, 0, 4'h2, 0, 0, 10, 4, 4'h0, 1, 0);
    add(5,  0, 0, 4'h0, 0, 0, 15, 4, 4'h0, 1, 0);
    add(1,  0, 0, 4'h0, 1, 1, 0,  5, 4'h2, 1, 0);
    add(1,  0, 0, 4'h0, 0, 0, 0,  5, 4'h0, 0, 0);
    add(40, 0, 1, 4'h0, 0, 0, 0,  5, 4'h0, 0, 0);
    add(1,  1, 1, 4'h0, 1, 1, 0,  0, 4'h0, 1, 0);
    add(1,  0, 0, 4'h0, 0, 0, 1,  0, 4'h0, 1, 1);
    add(24, 0, 0, 4'h0, 1, 0, 9,  1, 4'h0, 1, 1);
    #1 rst = 1;
    #1 chk_zero("reset");
    tick();
    tick();
    rst = 0;
    foreach (tbl[i]) begin
      start = tbl[i].st;
      stop = tbl[i].sp;
      clr_req = tbl[i].clr;
      ng = 0;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        ng += int'(grst);
      end
      start = 0;
      stop = 0;
      clr_req = '0;
      chk($sformatf("r%0d grst_seen", i), 32'(ng), 32'(tbl[i].ng));
      chk($sformatf("r%0d grst", i), 32'(grst), 32'(tbl[i].g));
      chk($sformatf("r%0d phase", i), 32'(gamma_phase), 32'(tbl[i].ph));
      chk($sformatf("r%0d count", i), 32'(gamma_count), 32'(tbl[i].cnt));
      chk($sformatf("r%0d mem_rst", i), 32'(mem_rst), 32'(tbl[i].m));
      chk($sformatf("r%0d clr_ack", i), 32'(clr_ack), 32'(tbl[i].m));
      chk($sformatf("r%0d busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("r%0d win", i), 32'(in_window), 32'(tbl[i].w));
    end
    #2 rst = 1;
    #1 chk_zero("async_rst_ph9");
    tick();
    tick();
    rst = 0;
    ng = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      ng += int'(grst) + int'(busy);
    end
    chk("post_rst_idle", 32'(ng), 0);
    start = 1;
    tick();
    start = 0;
    chk("restart grst", 32'(grst), 1);
    chk("restart phase", 32'(gamma_phase), 0);
    chk("restart count", 32'(gamma_count), 0);
    for (int k = 0; k < 16; k++) tick();
    chk("restart boundary grst", 32'(grst), 1);
    chk("restart boundary count", 32'(gamma_count), 1);
    #2 rst = 1;
    #1 chk_zero("async_rst_in_flight");
    tick();
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
